imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
// - Sequences the fetch stage's instruction-memory write path to boot-load a program from a host word stream.
// - Owns the fetch stage's RST, WE, W_Ins and newPC override while loading; then resets PC to 0 and releases the core.
// - Sits between the host/debug link and the fetch stage; the datapath newPC mux selects LD_PC when PC_OVR=1.
// PARAMETERS
// - IMEM_SIZE  64                  instruction memory depth in words (from common_param.vh)
// - CNT_W      $clog2(IMEM_SIZE)+1 word counter / LEN width (localparam, derived)
// PORTS
// - CLK      in   1      single clock; all state on posedge
// - RST      in   1      reset, asynchronous, active-high
// - START    in   1      load request, sampled in IDLE/RUN
// - LEN      in   CNT_W  words to load, sampled with START; legal 0..IMEM_SIZE
// - IN_VALID in   1      host word valid
// - IN_DATA  in   32     host word
// - IN_READY out  1      loader accepts word this cycle
// - IF_RST   out  1      drives fetch-stage RST (forces PC=0, blocks writes)
// - IF_WE    out  1      drives fetch-stage WE
// - IF_WINS  out  32     drives fetch-stage W_Ins
// - PC_OVR   out  1      1: newPC mux selects LD_PC
// - LD_PC    out  32     override next-PC value
// - CPU_RUN  out  1      core enabled (fetch runs from program)
// - BUSY     out  1      CLR/LOAD/FIN in progress
// - DONE     out  1      load complete, core running
// - ERR      out  1      sticky: START with LEN>IMEM_SIZE
// BEHAVIOUR
// - FSM states: IDLE, CLR, LOAD, FIN, RUN. Registers: state, cnt (CNT_W), len_q (CNT_W), err.
// - RST (async) -> IDLE, cnt=0, len_q=0, err=0. IDLE outputs: IF_RST=1, PC_OVR=1, LD_PC=0, IF_WE=0,
//   IN_READY=0, CPU_RUN=0, BUSY=0, DONE=0.
// - IDLE/RUN + START: LEN<=IMEM_SIZE -> CLR, len_q<=LEN, cnt<=0, err<=0; LEN>IMEM_SIZE -> IDLE, err<=1
//   (START in RUN with bad LEN also drops to IDLE: core halted, memory content undefined-partial not touched).
// - START ignored in CLR/LOAD/FIN.
// - CLR (1 cycle): IF_RST=1, PC_OVR=1, BUSY=1 -> fetch PC=0 at edge. Next: LOAD if len_q!=0 else FIN.
// - LOAD: IF_RST=0, PC_OVR=1, BUSY=1, IN_READY=1 (independent of IN_VALID).
//   IF_WE=IN_VALID (combinational), IF_WINS=IN_DATA. LD_PC = {cnt+IN_VALID, 2'b00} zero-extended to 32b.
//   -> fetch writes IMem[cnt] and PC advances to 4*(cnt+1) on accept; PC holds at 4*cnt on bubble.
//   Accept (IN_VALID&IN_READY): cnt<=cnt+1; if cnt+1==len_q -> FIN.
// - FIN (1 cycle): IF_RST=1, IF_WE=0, PC_OVR=1, BUSY=1 -> PC=0. Next: RUN.
// - RUN: IF_RST=0, PC_OVR=0, CPU_RUN=1, DONE=1, IF_WE=0, IN_READY=0. Stays until START.
// - Latency: START at edge n -> CLR cycle n+1, first accept possible at edge ending cycle n+2;
//   last accept at edge e -> FIN, RUN/DONE=1 at cycle after e+1. LEN=0: CLR,FIN,RUN (3 cycles).
// - IF_WE never 1 while IF_RST=1; IF_WE only in LOAD. LD_PC max = 4*IMEM_SIZE (never used as fetch addr).
// - RST mid-LOAD: immediate IDLE, partial program retained in IMem, core held in reset.
// - Extra host words after len_q reached: not accepted (IN_READY=0 from FIN on).
// - Outputs other than IF_WE/IF_WINS/LD_PC are pure functions of state (Moore).
// STRUCTURE
// - IMEM_SIZE stays in common_param.vh; add state encodings (ST_IDLE..ST_RUN, 3b) there.
// - Single module, no sub-modules; FSM + counter fit in one always block plus combinational outputs.
// TESTING
// - Reset: assert RST async mid-cycle -> all outputs at IDLE values same cycle; IF_RST=1, CPU_RUN=0.
// - START, LEN=4, words 0x20080005,0x20090003,0x01095020,0xAC0A0000 back-to-back -> IMem[0..3] match,
//   IF_WE high 4 cycles, LD_PC 4,8,12,16; FIN then DONE=1, PC=0, core executes from word 0.
// - LEN=3 with IN_VALID gaps (1 idle cycle between words) -> IF_WE=0 and LD_PC=4*cnt in gaps, IMem[0..2] correct, no shifted writes.
// - LEN=0 -> CLR,FIN,RUN in 3 cycles, no IF_WE pulse; LEN=IMEM_SIZE+1 -> ERR=1, stays IDLE.
// - LEN=IMEM_SIZE full load -> last LD_PC=256, IMem[63] written, 65th host word left unaccepted (IN_READY=0).
// - RST asserted after 2 of 4 words -> IDLE immediately, IMem[0..1] written, IMem[2..3] unchanged; START in RUN reloads.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: memory depth,
// counter width and the 3-bit FSM state encodings.
package imem_boot_loader_pkg;

    localparam int IMEM_SIZE = 64;
    localparam int CNT_W     = $clog2(IMEM_SIZE) + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_FIN  = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: takes over the fetch stage's reset, write port and next-PC
// mux to stream a host program into IMem, then restarts the core at PC 0.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] LEN,
    input  logic             IN_VALID,
    input  logic [31:0]      IN_DATA,
    output logic             IN_READY,
    output logic             IF_RST,
    output logic             IF_WE,
    output logic [31:0]      IF_WINS,
    output logic             PC_OVR,
    output logic [31:0]      LD_PC,
    output logic             CPU_RUN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(IMEM_SIZE);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic             err;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt_pc;

    assign cnt_inc    = cnt + 1'b1;
    assign cnt_nxt_pc = cnt + {{(CNT_W-1){1'b0}}, IN_VALID};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            len_q <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (START) begin
                        if (LEN <= LEN_MAX) begin
                            state <= ST_CLR;
                            len_q <= LEN;
                            cnt   <= '0;
                            err   <= 1'b0;
                        end else begin
                            // A bad length halts the core rather than leaving it on stale code.
                            state <= ST_IDLE;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_CLR:  state <= (len_q != '0) ? ST_LOAD : ST_FIN;
                ST_LOAD: begin
                    if (IN_VALID) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == len_q) state <= ST_FIN;
                    end
                end
                ST_FIN:  state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        IN_READY = 1'b0;
        IF_RST   = 1'b1;
        IF_WE    = 1'b0;
        IF_WINS  = '0;
        PC_OVR   = 1'b1;
        LD_PC    = '0;
        CPU_RUN  = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        case (state)
            ST_CLR, ST_FIN: BUSY = 1'b1;
            ST_LOAD: begin
                // PC tracks the write address: advance on accept, hold on bubble.
                IF_RST   = 1'b0;
                BUSY     = 1'b1;
                IN_READY = 1'b1;
                IF_WE    = IN_VALID;
                IF_WINS  = IN_DATA;
                LD_PC    = {{(32-CNT_W-2){1'b0}}, cnt_nxt_pc, 2'b00};
            end
            ST_RUN: begin
                IF_RST  = 1'b0;
                PC_OVR  = 1'b0;
                CPU_RUN = 1'b1;
                DONE    = 1'b1;
            end
            default: ;
        endcase
    end

    assign ERR = err;

endmodule
